alu_branch_unit: RTL
====================

ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/PC/target width (legal: 32, 64).
REQ-002 SHALL have parameter IALIGN, default 32, instruction alignment in bits (legal: 16, 32).
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  unit accepts request.
REQ-005 SHALL have ports: funct3  in  3  branch condition; op_jal  in  1  JAL; op_jalr  in  1  JALR (op_jal/op_jalr override funct3).
REQ-006 SHALL have ports: operand1, operand2, immediate, pc  in  XLEN each  (immediate pre-sign-extended).
REQ-007 SHALL have ports: flush  in  1  discard all in-flight requests.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; next_pc  out  XLEN; link_pc  out  XLEN (pc+4); taken  out  1; misaligned  out  1.
REQ-009 SHALL have ports (macro-dependent): branch_count, taken_count  out  32 each.

Function
REQ-010 SHALL decode funct3: 0 BEQ, 1 BNE, 4 BLT signed, 5 BGE signed, 6 BLTU, 7 BGEU; 2 and 3 are never taken.
REQ-011 SHALL be a 2-stage pipeline: stage 1 registers condition result and target; stage 2 holds result until out_ready; latency 2 cycles with out_ready high.
REQ-012 SHALL compute target: branch/JAL = pc+immediate; JALR = (operand1+immediate) with bit 0 cleared; all sums modulo 2^XLEN (wrap, no overflow flag).
REQ-013 SHALL set taken=1 for JAL/JALR unconditionally, else per REQ-010; next_pc = taken ? target : pc+4 (wraps).
REQ-014 SHALL set misaligned=1 when taken and target[1]=1 with IALIGN=32; always 0 with IALIGN=16; next_pc still reports the target.
REQ-015 SHALL accept a request when in_valid && in_ready; in_ready = !stage1_valid || !stage2_valid || out_ready (pipeline advances whenever downstream slot frees).
REQ-016 SHALL hold out_valid and all output payloads stable while out_valid && !out_ready.
REQ-017 SHALL sustain one request per cycle with out_ready held high; no bubbles inserted.
REQ-018 SHALL, on flush, clear both stage valids next cycle and ignore any same-cycle input request (in_ready still reported per REQ-015, acceptance dropped).
REQ-019 SHALL give flush priority over simultaneous accept and output handshake; output handshake in flush cycle still counts as consumed.
REQ-020 SHALL preserve request order; no request dropped or duplicated absent flush.

Reset
REQ-021 SHALL, with reset high at a clk edge, clear stage valids, out_valid=0, next_pc=0, link_pc=0, taken=0, misaligned=0, counters=0.
REQ-022 SHALL discard in-flight requests when reset asserts mid-operation; in_ready=1 first cycle after reset deasserts.
REQ-023 SHALL give reset priority over flush and all handshakes.

Configuration
REQ-024 SHALL, with macro ALU_BRANCH_STATS_EN defined, increment branch_count per output handshake of a conditional branch and taken_count per such handshake with taken=1 (JAL/JALR excluded; 32-bit wrap).
REQ-025 SHALL, without ALU_BRANCH_STATS_EN, tie branch_count and taken_count to 0 and instantiate no counter registers.

Verification
REQ-026 SHALL cover: BLT operand1=0xFFFFFFFF, operand2=1, pc=0x100, imm=0x20 -> 2 cycles later taken=1, next_pc=0x120; same with BLTU -> taken=0, next_pc=0x104.
REQ-027 SHALL cover: JALR operand1=0x1001, imm=2 -> next_pc=0x1002, link_pc=pc+4, misaligned=1 (IALIGN=32); IALIGN=16 -> misaligned=0.
REQ-028 SHALL cover: 4 back-to-back BEQ requests, out_ready low 3 cycles after first output -> in_ready low once both stages full, outputs stable, all 4 delivered in order.
REQ-029 SHALL cover: flush with 2 in flight plus same-cycle in_valid -> next cycle out_valid=0, no stale outputs, following request returns normally.
REQ-030 SHALL cover: pc=0xFFFFFFFC, BNE not taken -> next_pc=0x0; reset mid-stall -> all outputs zero next cycle.
REQ-031 SHALL cover (ALU_BRANCH_STATS_EN): 5 branches, 3 taken, 1 JAL -> branch_count=5, taken_count=3; without macro both 0.

Source files
------------

// File: rtl/alu_branch_unit.sv
// ---------------------------------------------------------------------------
// alu_branch_unit
//
// Branch/jump resolution unit. It evaluates the RISC-V style branch
// condition, computes the branch or jump target and the link address, and
// returns the resolved next PC through a 2-stage valid/ready pipeline.
//
// Parameters
//   XLEN    operand, PC and target width (32 or 64)
//   IALIGN  instruction alignment in bits (16 or 32). With 32, a taken
//           target that has bit 1 set raises 'misaligned'.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   funct3              branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   op_jal, op_jalr     unconditional jumps; they override funct3
//   operand1/2          compare operands (operand1 is also the JALR base)
//   immediate           pre-sign-extended offset
//   pc                  PC of the branch/jump
//   flush               drops every in-flight request and same-cycle input
//   out_valid/out_ready result handshake
//   next_pc             resolved PC (target if taken, else pc+4)
//   link_pc             pc+4
//   taken, misaligned   resolution flags
//   branch_count        conditional branches delivered (stats build only)
//   taken_count         taken conditional branches delivered (stats build only)
//
// Configuration
//   ALU_BRANCH_STATS_EN  when defined, enables the two 32-bit statistics
//                        counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module alu_branch_unit #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            op_jal,
    input  logic            op_jalr,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] link_pc,
    output logic            taken,
    output logic            misaligned,
    output logic [31:0]     branch_count,
    output logic [31:0]     taken_count
);

    localparam bit CHECK_ALIGN = (IALIGN == 32);

    // Condition evaluation; funct3 values 2 and 3 never take.
    function automatic logic branch_cond(input logic [2:0] f3,
                                         input logic signed [XLEN-1:0] a,
                                         input logic signed [XLEN-1:0] b);
        logic r;
        r = 1'b0;
        case (f3)
            3'd0:    r = (a == b);
            3'd1:    r = (a != b);
            3'd4:    r = (a < b);
            3'd5:    r = (a >= b);
            3'd6:    r = ($unsigned(a) < $unsigned(b));
            3'd7:    r = ($unsigned(a) >= $unsigned(b));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic signed [XLEN-1:0] op1_s_p0;
    logic signed [XLEN-1:0] op2_s_p0;
    logic [XLEN-1:0]        jalr_sum_p0;
    logic [XLEN-1:0]        target_p0;
    logic [XLEN-1:0]        seq_pc_p0;
    logic [XLEN-1:0]        next_pc_p0;
    logic                   taken_p0;
    logic                   mis_p0;

    logic                   vld_p1;
    logic [XLEN-1:0]        next_pc_p1;
    logic [XLEN-1:0]        link_pc_p1;
    logic                   taken_p1;
    logic                   mis_p1;

    logic                   vld_p2;
    logic [XLEN-1:0]        next_pc_p2;
    logic [XLEN-1:0]        link_pc_p2;
    logic                   taken_p2;
    logic                   mis_p2;

    logic                   accept;
    logic                   adv_p2;
    logic                   fire_out;

    // ---- stage 0: combinational resolution of the incoming request ----
    assign op1_s_p0    = operand1;
    assign op2_s_p0    = operand2;
    assign jalr_sum_p0 = operand1 + immediate;
    assign target_p0   = op_jalr ? {jalr_sum_p0[XLEN-1:1], 1'b0} : (pc + immediate);
    assign seq_pc_p0   = pc + XLEN'(4);
    assign taken_p0    = op_jal | op_jalr | branch_cond(funct3, op1_s_p0, op2_s_p0);
    assign next_pc_p0  = taken_p0 ? target_p0 : seq_pc_p0;
    assign mis_p0      = CHECK_ALIGN & taken_p0 & target_p0[1];

    // Stage 1 can take a new entry whenever it is empty or about to move
    // into stage 2 this cycle.
    assign in_ready = !vld_p1 || !vld_p2 || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign adv_p2   = vld_p1 && (!vld_p2 || out_ready);
    assign fire_out = vld_p2 && out_ready;

    // ---- stage 1: registered resolution ----
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (adv_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            next_pc_p1 <= next_pc_p0;
            link_pc_p1 <= seq_pc_p0;
            taken_p1   <= taken_p0;
            mis_p1     <= mis_p0;
        end
    end

    // ---- stage 2: output holding register ----
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= 1'b1;
        end else if (fire_out) begin
            vld_p2 <= 1'b0;
        end
    end

    // The output payload is architecturally visible after reset, so it is
    // cleared there; a flush only drops the valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_pc_p2 <= '0;
            link_pc_p2 <= '0;
            taken_p2   <= 1'b0;
            mis_p2     <= 1'b0;
        end else if (adv_p2) begin
            next_pc_p2 <= next_pc_p1;
            link_pc_p2 <= link_pc_p1;
            taken_p2   <= taken_p1;
            mis_p2     <= mis_p1;
        end
    end

    assign out_valid  = vld_p2;
    assign next_pc    = next_pc_p2;
    assign link_pc    = link_pc_p2;
    assign taken      = taken_p2;
    assign misaligned = mis_p2;

`ifdef ALU_BRANCH_STATS_EN
    logic br_p1;
    logic br_p2;

    always_ff @(posedge clk) begin
        if (accept) begin
            br_p1 <= !op_jal && !op_jalr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_p2 <= 1'b0;
        end else if (adv_p2) begin
            br_p2 <= br_p1;
        end
    end

    // A handshake in a flush cycle is still a delivered result, so fire_out
    // is deliberately not qualified by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (fire_out && br_p2) begin
            branch_count <= branch_count + 32'd1;
            if (taken_p2) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`else
    assign branch_count = '0;
    assign taken_count  = '0;
`endif

endmodule
